// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: read-return FSM states and the
// per-port request bundle, sized from the global memory geometry macros.
`ifndef MEM_SPACE
`define MEM_SPACE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

package dmem_pkg;

   localparam int MEM_SPACE = `MEM_SPACE;
   localparam int DSIZE     = `DSIZE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2
   } rd_state_t;

   typedef struct packed {
      logic                 req;
      logic                 we;
      logic [MEM_SPACE-1:0] addr;
      logic [DSIZE-1:0]     wdata;
   } port_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares single-port D_memory between the CPU MEM stage (port 0, fixed priority)
// and the loader/debug port (port 1, starvation-protected); routes reads back.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int AW       = MEM_SPACE,
   parameter int DW       = DSIZE,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p0_gnt,
   output logic          p1_gnt,
   output logic          p0_rvalid,
   output logic          p1_rvalid,
   output logic [DW-1:0] p0_rdata,
   output logic [DW-1:0] p1_rdata,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data_in,
   output logic          mem_write_en,
   input  logic [DW-1:0] mem_data_out
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] wait_cnt;
   logic          starved;
   rd_state_t     state;

   assign starved = (wait_cnt == CW'(MAX_WAIT));

   // Grants are held low during reset so nothing reaches the memory.
   always_comb begin
      p1_gnt = rst & p1_req & (~p0_req | starved);
      p0_gnt = rst & p0_req & ~p1_gnt;
   end

   assign mem_address  = p1_gnt ? p1_addr  : p0_addr;
   assign mem_data_in  = p1_gnt ? p1_wdata : p0_wdata;
   assign mem_write_en = (p0_gnt & p0_we) | (p1_gnt & p1_we);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (p1_gnt || !p1_req) begin
         wait_cnt <= '0;
      end else if (!starved) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // The state names which port owns the data the memory presents this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
      end else begin
         p0_rvalid <= (state == RD0);
         p1_rvalid <= (state == RD1);
         case (state)
            RD0:     p0_rdata <= mem_data_out;
            RD1:     p1_rdata <= mem_data_out;
            default: ;
         endcase
         if (p0_gnt && !p0_we) begin
            state <= RD0;
         end else if (p1_gnt && !p1_we) begin
            state <= RD1;
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural registered, read-before-write memory.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int AW = MEM_SPACE;
   localparam int DW = DSIZE;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_in;
   logic          mem_write_en;
   logic [DW-1:0] mem_data_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
      .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_write_en(mem_write_en), .mem_data_out(mem_data_out)
   );

   logic [DW-1:0] mem [0:255];
   logic          load_en = 1'b0;
   logic [7:0]    load_addr = '0;
   logic [DW-1:0] load_dat = '0;

   always @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_dat;
      else if (mem_write_en) mem[mem_address[7:0]] <= mem_data_in;
      mem_data_out <= mem[mem_address[7:0]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic port_req_t rd(input logic [AW-1:0] a);
      port_req_t r;
      r = '0; r.req = 1'b1; r.addr = a;
      return r;
   endfunction

   function automatic port_req_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      port_req_t r;
      r = '0; r.req = 1'b1; r.we = 1'b1; r.addr = a; r.wdata = d;
      return r;
   endfunction

   task automatic drive(input port_req_t a, input port_req_t b);
      p0_req = a.req; p0_we = a.we; p0_addr = a.addr; p0_wdata = a.wdata;
      p1_req = b.req; p1_we = b.we; p1_addr = b.addr; p1_wdata = b.wdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam port_req_t NONE = '0;
   logic [DW-1:0] b2b_dat [0:3];

   initial begin
      b2b_dat[0] = 16'h1111; b2b_dat[1] = 16'h2222;
      b2b_dat[2] = 16'h3333; b2b_dat[3] = 16'h4444;
      drive(NONE, NONE);
      tick();
      for (int i = 1; i <= 5; i++) begin
         load_en = 1'b1; load_addr = 8'(i);
         load_dat = (i == 5) ? 16'd1234 : b2b_dat[i-1];
         tick();
      end
      load_en = 1'b0;

      // Reset state with requests pending
      drive(wr(16'd9, 16'hAAAA), wr(16'd9, 16'h5555));
      @(negedge clk);
      check("rst_p0_gnt", 32'(p0_gnt), 0);
      check("rst_p1_gnt", 32'(p1_gnt), 0);
      check("rst_we", 32'(mem_write_en), 0);
      check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
      check("rst_rdata", {p0_rdata, p1_rdata}, 0);
      tick();
      drive(NONE, NONE);
      rst = 1'b1;
      tick();

      // Single port-0 read
      drive(rd(16'd5), NONE);
      @(negedge clk);
      check("rd_p0_gnt", 32'(p0_gnt), 1);
      check("rd_p1_gnt", 32'(p1_gnt), 0);
      check("rd_addr", 32'(mem_address), 5);
      check("rd_we", 32'(mem_write_en), 0);
      tick();
      drive(NONE, NONE);
      @(negedge clk);
      check("rd_rvalid_early", 32'(p0_rvalid), 0);
      tick();
      @(negedge clk);
      check("rd_rvalid", 32'(p0_rvalid), 1);
      check("rd_rdata", 32'(p0_rdata), 1234);
      check("rd_p1_rvalid", 32'(p1_rvalid), 0);
      tick();
      @(negedge clk);
      check("rd_rvalid_pulse", 32'(p0_rvalid), 0);
      check("rd_rdata_hold", 32'(p0_rdata), 1234);
      tick();

      // Back-to-back alternating reads of 1..4
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            if (i % 2 == 0) drive(rd(16'(i + 1)), NONE);
            else            drive(NONE, rd(16'(i + 1)));
         end else begin
            drive(NONE, NONE);
         end
         @(negedge clk);
         if (i < 4) check("b2b_gnt", {p0_gnt, p1_gnt}, (i % 2 == 0) ? 2 : 1);
         if (i >= 2) begin
            check("b2b_rvalid", {p0_rvalid, p1_rvalid}, (i % 2 == 0) ? 2 : 1);
            check("b2b_rdata", (i % 2 == 0) ? 32'(p0_rdata) : 32'(p1_rdata), 32'(b2b_dat[i-2]));
         end
         tick();
      end
      @(negedge clk);
      check("b2b_idle", {p0_rvalid, p1_rvalid}, 0);
      tick();

      // Port-1 write then read of address 3
      drive(NONE, wr(16'd3, 16'hBEEF));
      @(negedge clk);
      check("wr_p1_gnt", 32'(p1_gnt), 1);
      check("wr_we", 32'(mem_write_en), 1);
      check("wr_data", 32'(mem_data_in), 32'hBEEF);
      tick();
      drive(NONE, rd(16'd3));
      @(negedge clk);
      check("wrd_gnt", 32'(p1_gnt), 1);
      check("wrd_we", 32'(mem_write_en), 0);
      tick();
      drive(NONE, NONE);
      @(negedge clk);
      check("wr_no_rvalid", 32'(p1_rvalid), 0);
      tick();
      @(negedge clk);
      check("wrd_rvalid", 32'(p1_rvalid), 1);
      check("wrd_rdata", 32'(p1_rdata), 32'hBEEF);
      check("wrd_p0_hold", 32'(p0_rdata), 32'h3333);
      tick();
      @(negedge clk);
      check("wrd_pulse", 32'(p1_rvalid), 0);
      tick();

      // Starvation: port 0 continuous, port 1 waits exactly 4 cycles
      for (int k = 0; k < 7; k++) begin
         drive(rd(16'd1), (k <= 4) ? rd(16'd2) : NONE);
         @(negedge clk);
         if (k < 4) begin
            check("stv_blocked", {p0_gnt, p1_gnt}, 2);
            check("stv_wait", 32'(dut.wait_cnt), k);
         end else if (k == 4) begin
            check("stv_p1_gnt", {p0_gnt, p1_gnt}, 1);
            check("stv_wait_max", 32'(dut.wait_cnt), 4);
            check("stv_addr", 32'(mem_address), 2);
         end else begin
            check("stv_resume", {p0_gnt, p1_gnt}, 2);
            check("stv_wait_clr", 32'(dut.wait_cnt), 0);
         end
         if (k == 6) begin
            check("stv_p1_rvalid", 32'(p1_rvalid), 1);
            check("stv_p1_rdata", 32'(p1_rdata), 32'h2222);
         end
         tick();
      end

      // Port 1 drops its request at wait_cnt 3, then restarts the count
      for (int k = 0; k < 9; k++) begin
         drive(rd(16'd1), (k == 3) ? NONE : rd(16'd4));
         @(negedge clk);
         if (k < 3) check("drop_wait", 32'(dut.wait_cnt), k);
         else if (k == 3) check("drop_wait3", 32'(dut.wait_cnt), 3);
         else check("drop_rewait", 32'(dut.wait_cnt), k - 4);
         check("drop_gnt", {p0_gnt, p1_gnt}, (k == 8) ? 1 : 2);
         tick();
      end
      drive(NONE, NONE);
      tick();
      tick();
      tick();

      // Reset asserted while a port-0 read is in flight
      drive(rd(16'd5), NONE);
      @(negedge clk);
      check("mid_gnt", 32'(p0_gnt), 1);
      tick();
      drive(wr(16'd6, 16'h0F0F), NONE);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_gnt_forced", 32'(p0_gnt), 0);
      check("mid_we_forced", 32'(mem_write_en), 0);
      check("mid_rvalid", {p0_rvalid, p1_rvalid}, 0);
      check("mid_rdata", {p0_rdata, p1_rdata}, 0);
      tick();
      drive(NONE, NONE);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("mid_no_rvalid", {p0_rvalid, p1_rvalid}, 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory (`D_memory`) between the CPU MEM stage (port 0) and the loader/debug port (port 1). It grants at most one access per cycle and drives the memory's address, data and write-enable. It routes the memory's registered read data back to the requester that issued the read. Port 0 has fixed priority. A starvation counter guarantees port 1 a grant after `MAX_WAIT` consecutive blocked cycles.

## Interface
- `AW`, default `` `MEM_SPACE ``: memory address width.
- `DW`, default `` `DSIZE ``: data width.
- `MAX_WAIT`, default 4: consecutive blocked cycles after which port 1 overrides port 0. Legal range is 1..15.

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `p0_req`, `p1_req`  in  1  access request, held until granted
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read
- `p0_addr`, `p1_addr`  in  AW  word address
- `p0_wdata`, `p1_wdata`  in  DW  write data
- `p0_gnt`, `p1_gnt`  out  1  combinational grant; the access is taken at this rising edge
- `p0_rvalid`, `p1_rvalid`  out  1  registered one-cycle pulse; the read data is valid
- `p0_rdata`, `p1_rdata`  out  DW  read data, held until the next read for that port
- `mem_address`  out  AW  to `D_memory.address`
- `mem_data_in`  out  DW  to `D_memory.data_in`
- `mem_write_en`  out  1  to `D_memory.write_en`, active-high
- `mem_data_out`  in  DW  from `D_memory.data_out`, registered in memory

## Operation
- **Grant rule, evaluated combinationally each cycle:**
  - `p1_gnt = p1_req & (~p0_req | wait_cnt == MAX_WAIT)`.
  - `p0_gnt = p0_req & ~p1_gnt`.
  - Never both high.
- **Memory drive:**
  - `mem_address` and `mem_data_in` come from the granted port. With no grant they come from port 0.
  - `mem_write_en = (p0_gnt & p0_we) | (p1_gnt & p1_we)`.
- **Starvation counter `wait_cnt`**, width clog2(MAX_WAIT+1):
  - Increments when `p1_req & ~p1_gnt`.
  - Clears when `p1_gnt` or `~p1_req`.
  - Saturates at `MAX_WAIT`.
- **Read-return FSM, states IDLE / RD0 / RD1, updated every edge:**
  - Next state is RD0 on a `p0_gnt & ~p0_we` edge.
  - Next state is RD1 on a `p1_gnt & ~p1_we` edge.
  - Otherwise next state is IDLE.
  - A write grant leaves the FSM in IDLE. Writes return no `rvalid` and need no handshake beyond `gnt`.
- **Read return:**
  - In RD0, `p0_rdata` captures `mem_data_out` and `p0_rvalid` pulses for one cycle on the following edge. RD1 does the same for port 1.
  - The `rdata` registers update only on their own port's read.
- **Back-to-back grants** are legal every cycle. Return pipelining means RDx and a new grant overlap without stall.
- **Reset while `rst` is low:**
  - Both `gnt` outputs forced 0 and `mem_write_en` forced 0.
  - FSM = IDLE, `wait_cnt` = 0.
  - Both `rvalid` = 0 and both `rdata` = 0.
  - Any in-flight read is dropped; no `rvalid` is issued after reset release.

## Timing
- **Read latency:**
  - Grant edge T: the memory registers the data at T.
  - The arbiter samples it at T+1.
  - `rvalid`/`rdata` are visible from T+1 until T+2.
  - Total is 2 cycles from request to `rvalid` when uncontended.
- **Write:** memory updated at grant edge T. A read of the same address granted at T+1 returns the new value.
- **Same-cycle read and write:** `D_memory` returns old data (read-before-write), and the arbiter passes that through unchanged.
- **Worst-case port-1 wait under continuous port-0 traffic:** exactly `MAX_WAIT` blocked cycles, then granted on the next cycle. After that grant port 0 resumes.
- **Requester rules:**
  - Hold `req`/`we`/`addr`/`wdata` stable until `gnt` is sampled high.
  - Dropping `req` before grant is permitted; for port 1 it clears `wait_cnt`.
- **Reset release:** `rst` deasserts asynchronously but is synchronised externally. The first grant is possible in the first cycle with `rst` high.

## Structure
- **Shared package `dmem_pkg`:**
  - The FSM state enum (IDLE, RD0, RD1).
  - A port-request struct {req, we, addr, wdata}, parameterised widths via `` `MEM_SPACE ``/`` `DSIZE `` from `define.v`.
- **Sub-modules:** none required. A single module holds the grant logic, counter, FSM and return registers.
- **Top level:** instantiates `dmem_arbiter` beside `D_memory`, wiring the `mem_*` ports directly.

## Test plan
1. **Reset:** assert `rst`=0 mid-read (FSM RD0) → all `rvalid`/`gnt`/`mem_write_en`=0 and `rdata`=0. No `rvalid` appears after release.
2. **Single read:** port-0 read of addr 5 holding 16'd1234 → `p0_gnt` at T, `p0_rvalid`=1 with `p0_rdata`=1234 at T+1 only.
3. **Write then read:** port-1 write addr 3 ← 16'hBEEF, then port-1 read addr 3 → `p1_rvalid` with 16'hBEEF. `p1_rvalid` stays low for the write.
4. **Starvation:** `p0_req` held high continuously, `p1_req` raised at cycle 0, `MAX_WAIT`=4 → `p1_gnt` first at cycle 4, `wait_cnt` 0→4→0, then `p0_gnt` resumes at cycle 5.
5. **Back-to-back reads:** alternating port reads of addrs 1,2,3,4 on consecutive cycles → `rvalid` pulses on consecutive cycles, each routed to the correct port with the correct data. The FSM never stalls.
6. **Port 1 drops request:** `p1_req` dropped at `wait_cnt`=3 and re-raised → `wait_cnt` restarts from 0, so grant comes after 4 more blocked cycles.
